// File: rtl/latch_bank_write_arbiter.sv
// -----------------------------------------------------------------------------
// latch_bank_write_arbiter
//
// Round-robin write controller for a shared bank of level-sensitive D latches.
// One requester is granted at a time; its address and data are captured, then
// the latch enable is sequenced as SETUP (data stable, enable low), OPEN (one
// enable high), HOLD (enable low, data still stable), DONE (ACK pulse). The
// data bus is only ever changed on a grant, so D is stable around the window.
//
// Ports:
//   CLK   in   system clock, rising edge
//   RST   in   synchronous active-high reset
//   REQ   in   [N_REQ]       per-requester write request level
//   ADDR  in   [N_REQ*AW]    packed latch index, requester i at [i*AW +: AW]
//   DIN   in   [N_REQ*W]     packed write data,  requester i at [i*W  +: W]
//   LD    out  [W]           shared latch data bus
//   LEN   out  [N_LATCH]     one-hot latch enables (latch CLK inputs)
//   ACK   out  [N_REQ]       one-cycle completion pulse to the served requester
//   ERR   out                with ACK, set when the address was out of range
//   BUSY  out                high from SETUP through DONE
//   CUR   out  [clog2 N_REQ] current / last granted requester
// -----------------------------------------------------------------------------
module latch_bank_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int N_LATCH   = 8,
  parameter int W         = 8,
  parameter int AW        = (N_LATCH > 1) ? $clog2(N_LATCH) : 1,
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC  = 2,
  parameter int HOLD_CYC  = 1,
  localparam int CW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [N_REQ-1:0]      REQ,
  input  logic [N_REQ*AW-1:0]   ADDR,
  input  logic [N_REQ*W-1:0]    DIN,
  output logic [W-1:0]          LD,
  output logic [N_LATCH-1:0]    LEN,
  output logic [N_REQ-1:0]      ACK,
  output logic                  ERR,
  output logic                  BUSY,
  output logic [CW-1:0]         CUR
);

  localparam int MAXC12 = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
  localparam int MAXC   = (MAXC12 > HOLD_CYC) ? MAXC12 : HOLD_CYC;
  localparam int PW     = $clog2(MAXC + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_OPEN, S_HOLD, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        ptr_q, ptr_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [W-1:0]         ld_q, ld_d;
  logic [N_LATCH-1:0]   len_q, len_d;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic                 err_q, err_d;
  logic                 eflag_q, eflag_d;
  logic                 busy_q, busy_d;
  logic [CW-1:0]        cur_q, cur_d;

  // Unpacked views of the packed request buses.
  logic [AW-1:0]        addr_arr [N_REQ];
  logic [W-1:0]         din_arr  [N_REQ];
  logic [N_REQ-1:0]     ack_sel;
  logic [N_LATCH-1:0]   onehot;
  // One entry per encodable address; marks which codes map to a real latch.
  logic [(1<<AW)-1:0]   in_range_map;
  logic                 in_range;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign addr_arr[gi] = ADDR[gi*AW +: AW];
      assign din_arr[gi]  = DIN[gi*W +: W];
      assign ack_sel[gi]  = (cur_q == CW'(gi));
    end
    for (gi = 0; gi < N_LATCH; gi++) begin : g_len
      assign onehot[gi] = (addr_q == AW'(gi));
    end
    for (gi = 0; gi < (1 << AW); gi++) begin : g_rng
      assign in_range_map[gi] = (gi < N_LATCH) ? 1'b1 : 1'b0;
    end
  endgenerate

  assign in_range = in_range_map[addr_q];

  // Round-robin search: first set REQ bit strictly after the pointer, wrapping.
  logic          found;
  logic [CW-1:0] win;
  logic [CW-1:0] rr_idx;

  always_comb begin
    found  = 1'b0;
    win    = '0;
    rr_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      rr_idx = CW'((int'(ptr_q) + k) % N_REQ);
      if (!found && REQ[rr_idx]) begin
        found = 1'b1;
        win   = rr_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    ld_d    = ld_q;
    len_d   = len_q;
    ack_d   = '0;
    err_d   = 1'b0;
    eflag_d = eflag_q;
    busy_d  = busy_q;
    cur_d   = cur_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          addr_d  = addr_arr[win];
          ld_d    = din_arr[win];
          cur_d   = win;
          ptr_d   = win;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == PW'(SETUP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_OPEN;
          // Enable is registered, so it is set on the edge entering OPEN.
          if (in_range) len_d = onehot;
          else          eflag_d = 1'b1;
        end else begin
          cnt_d = cnt_q + PW'(1);
        end
      end
      S_OPEN: begin
        if (cnt_q == PW'(OPEN_CYC - 1)) begin
          cnt_d   = '0;
          len_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + PW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == PW'(HOLD_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
          ack_d   = ack_sel;
          err_d   = eflag_q;
        end else begin
          cnt_d = cnt_q + PW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        eflag_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= CW'(N_REQ - 1);
      addr_q  <= '0;
      ld_q    <= '0;
      len_q   <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      eflag_q <= 1'b0;
      busy_q  <= 1'b0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      ld_q    <= ld_d;
      len_q   <= len_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      eflag_q <= eflag_d;
      busy_q  <= busy_d;
      cur_q   <= cur_d;
    end
  end

  assign LD   = ld_q;
  assign LEN  = len_q;
  assign ACK  = ack_q;
  assign ERR  = err_q;
  assign BUSY = busy_q;
  assign CUR  = cur_q;

endmodule

// File: tb/tb_latch_bank_write_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for latch_bank_write_arbiter. Uses a 6-latch bank (so addresses 6
// and 7 are out of range) and distinct phase lengths SETUP=2, OPEN=3, HOLD=2.
// Stimulus computes each grant at transaction level and queues the expected
// transaction; a negedge monitor derives the expected outputs for the cycle
// from the head transaction's timeline and retires it at its ACK cycle.
// -----------------------------------------------------------------------------
module tb_latch_bank_write_arbiter;

  localparam int N_REQ = 4;
  localparam int N_LATCH = 6;
  localparam int W = 8;
  localparam int AW = 3;
  localparam int S = 2;
  localparam int O = 3;
  localparam int H = 2;
  localparam int CW = 2;

  logic                clk = 1'b0;
  logic                RST = 1'b1;
  logic [N_REQ-1:0]    REQ = '0;
  logic [N_REQ*AW-1:0] ADDR = '0;
  logic [N_REQ*W-1:0]  DIN = '0;
  logic [W-1:0]        LD;
  logic [N_LATCH-1:0]  LEN;
  logic [N_REQ-1:0]    ACK;
  logic                ERR;
  logic                BUSY;
  logic [CW-1:0]       CUR;

  latch_bank_write_arbiter #(
    .N_REQ(N_REQ), .N_LATCH(N_LATCH), .W(W), .AW(AW),
    .SETUP_CYC(S), .OPEN_CYC(O), .HOLD_CYC(H)
  ) dut (
    .CLK(clk), .RST(RST), .REQ(REQ), .ADDR(ADDR), .DIN(DIN),
    .LD(LD), .LEN(LEN), .ACK(ACK), .ERR(ERR), .BUSY(BUSY), .CUR(CUR)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         g;      // cycle in which the grant was sampled
    int         w;      // winning requester
    int         addr;
    logic [W-1:0] data;
    bit         err;
  } tx_t;

  tx_t  q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   checking = 0;
  int   m_ptr = N_REQ - 1;
  int   m_free = 0;
  logic [W-1:0] last_ld = '0;
  int   last_cur = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs and update the transaction-level model.
  task automatic step(input bit r, input logic [N_REQ-1:0] rq,
                      input logic [N_REQ*AW-1:0] ad, input logic [N_REQ*W-1:0] dn);
    tx_t t;
    int  w;
    int  idx;
    @(posedge clk);
    #1;
    cyc++;
    RST = r; REQ = rq; ADDR = ad; DIN = dn;
    if (!r) checking = 1;
    if (r) begin
      m_ptr  = N_REQ - 1;
      m_free = cyc + 1;
    end else if (cyc >= m_free && rq != '0) begin
      w = -1;
      for (int k = 1; k <= N_REQ; k++) begin
        idx = (m_ptr + k) % N_REQ;
        if (w < 0 && rq[idx]) w = idx;
      end
      t.g    = cyc;
      t.w    = w;
      t.addr = int'(ad[w*AW +: AW]);
      t.data = dn[w*W +: W];
      t.err  = (t.addr >= N_LATCH);
      q.push_back(t);
      m_ptr  = w;
      m_free = cyc + 1 + S + O + H + 1;
      $display("grant cycle %0d req %0d addr %0d data 0x%02h err %0d",
               cyc, w, t.addr, t.data, t.err);
    end
  endtask

  function automatic logic [N_REQ*AW-1:0] rand_addr(input int maxa);
    logic [N_REQ*AW-1:0] v;
    v = '0;
    for (int i = 0; i < N_REQ; i++) v[i*AW +: AW] = AW'($urandom_range(0, maxa));
    return v;
  endfunction

  // Monitor: expected outputs for this cycle come from the head transaction.
  always @(negedge clk) begin
    if (checking) begin
      logic [31:0] e_len, e_ack, e_ld, e_cur;
      logic        e_busy, e_err;
      int          a;
      e_busy = 1'b0; e_len = '0; e_ack = '0; e_err = 1'b0;
      e_ld = 32'(last_ld); e_cur = 32'(last_cur); a = -1;
      if (q.size() > 0 && cyc > q[0].g) begin
        a = q[0].g + 1 + S + O + H;
        e_busy = 1'b1;
        e_ld   = 32'(q[0].data);
        e_cur  = 32'(q[0].w);
        if (cyc >= q[0].g + S + 1 && cyc <= q[0].g + S + O && !q[0].err)
          e_len = 32'(1) << q[0].addr;
        if (cyc == a) begin
          e_ack = 32'(1) << q[0].w;
          e_err = q[0].err;
        end
      end
      chk("LD", 32'(LD), e_ld);
      chk("LEN", 32'(LEN), e_len);
      chk("ACK", 32'(ACK), e_ack);
      chk("ERR", 32'(ERR), 32'(e_err));
      chk("BUSY", 32'(BUSY), 32'(e_busy));
      chk("CUR", 32'(CUR), e_cur);
      if (cyc == a) begin
        $display("ack cycle %0d req %0d err %0d ld 0x%02h", cyc, q[0].w, ERR, LD);
        last_ld  = q[0].data;
        last_cur = q[0].w;
        q.delete(0);
      end
      if (RST) begin
        q.delete();
        last_ld  = '0;
        last_cur = 0;
      end
    end
  end

  initial begin
    logic r;
    logic [N_REQ-1:0] rq;
    repeat (3) step(1, '0, '0, '0);

    // Single write, then the requester changes its address/data after capture.
    step(0, 4'b0001, 12'h003, 32'h000000A5);
    step(0, 4'b0001, 12'h001, 32'h0000003C);
    repeat (10) step(0, '0, 12'h001, 32'h0000003C);

    // Out-of-range address.
    step(0, 4'b0001, 12'h007, 32'h0000005A);
    repeat (10) step(0, '0, '0, '0);

    // Fairness under constant full request.
    repeat (50) step(0, 4'b1111, rand_addr(N_LATCH - 1), $urandom);
    repeat (10) step(0, '0, '0, '0);

    // Reset during OPEN, then all requesters ask again.
    step(0, 4'b0100, 12'h200, 32'h00770000);
    repeat (2) step(0, '0, '0, '0);
    step(1, '0, '0, '0);
    repeat (12) step(0, 4'b1111, rand_addr(7), $urandom);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      rq = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      step(r, rq, rand_addr(7), $urandom);
    end

    repeat (20) step(0, '0, '0, '0);
    @(posedge clk);
    #1;
    chk("QUEUE_EMPTY", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/latch_bank_write_arbiter.md
Name: latch_bank_write_arbiter

Overview:
Round-robin write controller that shares one bank of N_LATCH gate-level D latches (W bits each, D/CLK-enable style) among N_REQ requesters. It captures one winner's address and data, then sequences the latch enable in three phases: data setup, enable open, data hold. Each phase lasts a fixed number of cycles, so D is always stable around the enable window. It sits between requesting logic and the latch bank, driving the shared D bus and the per-latch enable (CLK) lines.

Parameters:
N_REQ, 4, number of requesters (>=2)
N_LATCH, 8, number of latches/words in the bank (>=2)
W, 8, data width per latch word
AW, clog2(N_LATCH) (min 1), address width per requester
SETUP_CYC, 1, cycles LD is stable before enable rises (>=1)
OPEN_CYC, 2, cycles enable is held high (>=1)
HOLD_CYC, 1, cycles LD stays stable after enable falls (>=1)

Ports:
CLK  in  1  system clock; all state updates on rising edge
RST  in  1  reset; synchronous and active-high
REQ  in  N_REQ  per-requester write request level
ADDR  in  N_REQ*AW  packed target latch index; requester i at bits [i*AW +: AW]
DIN  in  N_REQ*W  packed write data; requester i at bits [i*W +: W]
LD  out  W  shared data bus to all latch D inputs
LEN  out  N_LATCH  one-hot latch enables, driven to the latch CLK inputs
ACK  out  N_REQ  one-cycle one-hot completion pulse to the served requester
ERR  out  1  one-cycle pulse coincident with ACK when the address was out of range
BUSY  out  1  high from SETUP through ACK state
CUR  out  clog2(N_REQ)  index of the current/last granted requester

Behaviour:
- Reset (RST high at an edge): state=IDLE, LEN=0, LD=0, ACK=0, ERR=0, BUSY=0, CUR=0, round-robin pointer=N_REQ-1 (requester 0 wins first).
  - Reset overrides everything, including mid-phase. LEN drops at that edge, no ACK is issued, and the aborted request is forgotten.
- FSM states: IDLE, SETUP, OPEN, HOLD, DONE. All outputs are registered.
- IDLE: REQ is sampled every cycle. If any bit is set, the controller grants the first set bit searching upward from pointer+1 with wraparound.
  - The winner's ADDR and DIN are captured into registers, and LD <= captured DIN.
  - CUR <= winner, pointer <= winner, BUSY <= 1, state -> SETUP.
  - If REQ=0, stay in IDLE.
- SETUP: lasts SETUP_CYC cycles. LEN=0, LD stable. Then -> OPEN.
- OPEN: lasts OPEN_CYC cycles. LEN = one-hot(captured addr) if addr < N_LATCH; otherwise LEN=0 and an error flag is set. Then -> HOLD.
- HOLD: lasts HOLD_CYC cycles. LEN=0, LD stable. Then -> DONE.
- DONE: lasts 1 cycle. ACK[CUR]=1, and ERR=error flag. Then -> IDLE with BUSY=0 and the error flag cleared.
- Latency:
  - REQ seen in cycle 0 gives SETUP in cycles 1..S, LEN high in cycles S+1..S+O, HOLD following, and ACK in cycle 1+S+O+H.
  - With defaults, ACK is in cycle 5 and the earliest next grant is sampled in cycle 6, so back-to-back throughput is 1 write per 6 cycles.
- LD changes only on a grant; it holds its value in IDLE/DONE. At most one LEN bit is ever high, and never outside OPEN.
- REQ, ADDR and DIN are ignored after capture. Deasserting REQ mid-transaction does not abort it; ACK still pulses.
- A requester still holding REQ after its ACK is treated as a new request and is subject to round-robin order.
- The phase counter is internal and sized for max(SETUP_CYC, OPEN_CYC, HOLD_CYC). It wraps to 0 at each phase change.

Test Plan:
- Single write: REQ=0001, ADDR0=3, DIN0=0xA5 in cycle 0 -> cycle 1 LD=0xA5, LEN=0; cycles 2-3 LEN=0x08; cycle 4 LEN=0; cycle 5 ACK=0001, ERR=0; BUSY=1 in cycles 1-5.
- Fairness: REQ=1111 held constantly -> CUR sequence 0,1,2,3,0, with ACK pulses in cycles 5, 11, 17, 23, 29 and exactly one LEN bit at any time.
- Out of range (N_LATCH=6): ADDR0=7 -> LEN=0 throughout; cycle 5 ACK=0001 and ERR=1.
- Reset mid-OPEN: RST high in cycle 2 -> cycle 3 LEN=0, BUSY=0, LD=0, no ACK ever; the next REQ=1111 grants requester 0.
- Phase lengths (SETUP=2, OPEN=3, HOLD=2): REQ in cycle 0 -> LEN high in cycles 3-5 only; ACK in cycle 8.
- Capture isolation: DIN0 changes 0xA5 to 0x3C and ADDR0 changes 3 to 1 in cycle 1 -> LD stays 0xA5 and LEN=0x08 through HOLD.
